sync_ram_dp: RTL
================

Name: sync_ram_dp

Overview:
Parametrised simple-dual-port synchronous RAM, successor to the team's single-port RAM.
- Port A: read/write with per-byte write enables. Port B: read-only.
- Adds a selectable read-during-write mode, an optional output pipeline register and per-port read-valid strobes.
- Adds a hardware clear sequencer that zeroes the whole array after reset or on request.
- Sits between bus-side buffers and datapath engines that need deterministic contents without a software init loop.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH.
- ADDR_WIDTH, 6, address width; DEPTH = 2**ADDR_WIDTH words.
- BYTE_WIDTH, 8, bits per write-enable lane; NB = DATA_WIDTH/BYTE_WIDTH.
- RW_MODE, 0, same-address read during write: 0 = read-first (old data), 1 = write-first (new merged data).
- OUT_REG, 0, 0 = read latency 1 cycle; 1 = extra output register, read latency 2 cycles.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear request, sampled in READY only.
- init_busy  out  1  high while the clear sweep runs; ports ignored.
- a_en  in  1  port A access enable.
- a_we  in  NB  port A byte write enables; write occurs when a_en && |a_we.
- a_addr  in  ADDR_WIDTH  port A address.
- a_din  in  DATA_WIDTH  port A write data.
- a_dout  out  DATA_WIDTH  port A read data.
- a_valid  out  1  a_dout carries data for an accepted access.
- b_en  in  1  port B read enable.
- b_addr  in  ADDR_WIDTH  port B address.
- b_dout  out  DATA_WIDTH  port B read data.
- b_valid  out  1  b_dout carries data for an accepted read.

Behaviour:
- Reset (rst_n low, async): state=INIT, sweep counter=0, a_dout=b_dout=0, a_valid=b_valid=0, pipeline stages cleared, init_busy=1. The array itself is not reset; the sweep zeroes it.
- FSM states: INIT, READY.
- INIT:
  - Writes 0 to address cnt each cycle; cnt increments.
  - At cnt=DEPTH-1, the write completes and the next state is READY.
  - The sweep takes exactly DEPTH cycles after rst_n deassertion, then init_busy drops.
  - a_en, b_en and clr are ignored in INIT; valids stay 0; douts hold their value.
- READY:
  - clr=1 -> INIT with cnt=0; the access presented in that same cycle is dropped.
  - Accesses already in the pipeline complete and their valids still assert.
- Port A access (a_en=1 in READY): for each lane i with a_we[i]=1, mem[a_addr] lane i <= a_din lane i. Other lanes are untouched.
- Read capture: every accepted access on either port (including port A writes) produces a read of its address.
  - Stage 1 captures the data on the next edge.
  - OUT_REG=1 adds a second register stage.
  - valid follows the data with identical latency: 1 cycle after the enable edge (OUT_REG=0) or 2 cycles (OUT_REG=1).
- No access: valid=0 and dout holds its previous value (not zeroed).
- Same-address collision: port A writing while port A or port B reads the same address in the same cycle.
  - RW_MODE=0: the read returns pre-write contents.
  - RW_MODE=1: the read returns post-write merged contents (written lanes new, unwritten lanes old).
- Different addresses: no interaction. Back-to-back accesses are fully pipelined, one per cycle per port.
- Reset asserted mid-operation: in-flight reads are discarded, valids drop immediately, and the sweep restarts at address 0.
- clr during an active sweep is ignored.
- Address arithmetic wraps naturally at ADDR_WIDTH bits; there is no out-of-range condition.

Test Plan:
- Release rst_n (DEPTH=64) -> init_busy high for exactly 64 cycles; then reads of addresses 0, 31 and 63 on port B return 0x00000000 with b_valid 1 cycle after b_en.
- Port A write 0xAABBCCDD to addr 5 with a_we=4'b0101 -> port B read of addr 5 returns 0x00BB00DD. A full write 0x11223344 followed by a_we=4'b1000 with 0xFF000000 -> read returns 0xFF223344.
- Collision: mem[9]=0x12345678; A writes 0xCAFEF00D (a_we=4'hF) to addr 9 while B reads addr 9 in the same cycle -> RW_MODE=0 gives b_dout=0x12345678; RW_MODE=1 gives b_dout=0xCAFEF00D.
- OUT_REG=1: B reads addresses 1,2,3 on consecutive cycles -> b_valid asserts 2 cycles after each enable, three consecutive valid cycles with data in order; with b_en then low, b_dout holds the addr-3 data.
- After filling addresses with nonzero data, pulse clr -> init_busy high for 64 cycles, a_en accesses during the sweep have no effect, and afterwards all reads return 0.
- Assert rst_n low at sweep cycle 20, release -> init_busy stays high a full 64 cycles after release, and valids remain 0 throughout.

Source files
------------

// File: rtl/sync_ram_dp.sv
// Simple-dual-port RAM (A: r/w with byte enables, B: read) with hardware zero-sweep after reset or clr.
// Read latency 1 cycle (2 with OUT_REG); no backpressure, one access per port per cycle, ports ignored while init_busy.
module sync_ram_dp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int BYTE_WIDTH = 8,
  parameter int RW_MODE    = 0,
  parameter int OUT_REG    = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clr,
  output logic                             init_busy,
  input  logic                             a_en,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] a_we,
  input  logic [ADDR_WIDTH-1:0]            a_addr,
  input  logic [DATA_WIDTH-1:0]            a_din,
  output logic [DATA_WIDTH-1:0]            a_dout,
  output logic                             a_valid,
  input  logic                             b_en,
  input  logic [ADDR_WIDTH-1:0]            b_addr,
  output logic [DATA_WIDTH-1:0]            b_dout,
  output logic                             b_valid
);

  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  ready;
  logic                  a_acc;
  logic                  b_acc;
  logic                  a_wr;
  logic [DATA_WIDTH-1:0] a_old;
  logic [DATA_WIDTH-1:0] b_old;
  logic [DATA_WIDTH-1:0] a_merged;
  logic [DATA_WIDTH-1:0] a_rd;
  logic [DATA_WIDTH-1:0] b_rd;

  logic                  a_s1_vld;
  logic                  b_s1_vld;
  logic [DATA_WIDTH-1:0] a_s1_dat;
  logic [DATA_WIDTH-1:0] b_s1_dat;

  assign ready     = (state == ST_READY);
  assign init_busy = ~ready;

  // A clr cycle drops the access presented alongside it.
  assign a_acc = ready & a_en & ~clr;
  assign b_acc = ready & b_en & ~clr;
  assign a_wr  = a_acc & (|a_we);

  assign a_old = mem[a_addr];
  assign b_old = mem[b_addr];

  always_comb begin
    a_merged = a_old;
    for (int i = 0; i < NB; i++) begin
      if (a_we[i]) begin
        a_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = a_din[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Write-first only differs from read-first when port A writes the address being read.
  assign a_rd = (RW_MODE == 1) ? a_merged : a_old;
  assign b_rd = ((RW_MODE == 1) && a_wr && (b_addr == a_addr)) ? a_merged : b_old;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          cnt <= cnt + CNT_ONE;
          if (cnt == CNT_LAST) begin
            state <= ST_READY;
          end
        end
        ST_READY: begin
          if (clr) begin
            state <= ST_INIT;
            cnt   <= '0;
          end
        end
        default: begin
          state <= ST_INIT;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!ready) begin
      mem[cnt] <= '0;
    end else if (a_wr) begin
      for (int i = 0; i < NB; i++) begin
        if (a_we[i]) begin
          mem[a_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= a_din[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_s1_vld <= 1'b0;
      b_s1_vld <= 1'b0;
      a_s1_dat <= '0;
      b_s1_dat <= '0;
    end else begin
      a_s1_vld <= a_acc;
      b_s1_vld <= b_acc;
      if (a_acc) begin
        a_s1_dat <= a_rd;
      end
      if (b_acc) begin
        b_s1_dat <= b_rd;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  a_s2_vld;
      logic                  b_s2_vld;
      logic [DATA_WIDTH-1:0] a_s2_dat;
      logic [DATA_WIDTH-1:0] b_s2_dat;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_s2_vld <= 1'b0;
          b_s2_vld <= 1'b0;
          a_s2_dat <= '0;
          b_s2_dat <= '0;
        end else begin
          a_s2_vld <= a_s1_vld;
          b_s2_vld <= b_s1_vld;
          if (a_s1_vld) begin
            a_s2_dat <= a_s1_dat;
          end
          if (b_s1_vld) begin
            b_s2_dat <= b_s1_dat;
          end
        end
      end

      assign a_dout  = a_s2_dat;
      assign a_valid = a_s2_vld;
      assign b_dout  = b_s2_dat;
      assign b_valid = b_s2_vld;
    end else begin : g_no_out_reg
      assign a_dout  = a_s1_dat;
      assign a_valid = a_s1_vld;
      assign b_dout  = b_s1_dat;
      assign b_valid = b_s1_vld;
    end
  endgenerate

endmodule
